// File: rtl/decode_queue.sv
`timescale 1ns/1ps
// decode_queue: assembles a 1/2-byte instruction stream into decoded entries
// and buffers them in a small FIFO whose head is presented on registered outputs.
module decode_queue #(
    parameter int unsigned QDEPTH      = 2,
    parameter bit          SEXT_BRANCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_opcode,
    output logic [15:0] out_rhs,
    output logic [1:0]  out_len,
    output logic [3:0]  out_class,
    output logic [3:0]  count
);

    localparam int unsigned PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned MEMD = 1 << PW;
    localparam int unsigned CW   = 4;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] rhs;
        logic [1:0]  len;
        logic [3:0]  cls;
    } entry_t;

    typedef enum logic {
        OPC = 1'b0,
        OPR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      opc_q, opc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    entry_t          head_q, head_d;
    entry_t          mem_q [MEMD];

    logic            pop;
    logic            push;
    logic            accept;
    entry_t          new_entry;
    logic [3:0]      opr_cls;

    // Opcode to class code map; anything unlisted is ILLEGAL.
    function automatic logic [3:0] class_of(input logic [7:0] op);
        logic [3:0] c;
        if (op == 8'h00)                          c = 4'd0;
        else if (op == 8'h01)                     c = 4'd1;
        else if (op >= 8'h03 && op <= 8'h06)      c = 4'd2;
        else if (op == 8'h07)                     c = 4'd3;
        else if (op == 8'h08)                     c = 4'd4;
        else if (op == 8'h0A)                     c = 4'd5;
        else if (op >= 8'h80 && op <= 8'h87)      c = 4'd6;
        else if (op >= 8'h90 && op <= 8'h97)      c = 4'd7;
        else if ((op >= 8'h88 && op <= 8'h8F) ||
                 (op >= 8'h98 && op <= 8'hB7))    c = 4'd8;
        else if (op >= 8'hC0 && op <= 8'hC7)      c = 4'd9;
        else if (op >= 8'hD0 && op <= 8'hD7)      c = 4'd10;
        else if (op >= 8'hF0 && op <= 8'hF7)      c = 4'd11;
        else                                      c = 4'd15;
        return c;
    endfunction

    // Pointer increment with explicit wrap so non-power-of-two storage never aliases.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    assign out_valid  = valid_q;
    assign out_opcode = head_q.opcode;
    assign out_rhs    = head_q.rhs;
    assign out_len    = head_q.len;
    assign out_class  = head_q.cls;
    assign count      = count_q;

    // Handshake, assembler next-state, queue bookkeeping and next head entry.
    always_comb begin
        pop       = valid_q && out_ready && !flush;
        in_ready  = rst_n && !flush && ((count_q < CW'(QDEPTH)) || pop);
        accept    = in_valid && in_ready;
        state_d   = state_q;
        opc_d     = opc_q;
        push      = 1'b0;
        new_entry = '0;
        opr_cls   = class_of(opc_q);

        case (state_q)
            OPC: begin
                if (accept) begin
                    if (!in_byte[7]) begin
                        push             = 1'b1;
                        new_entry.opcode = in_byte;
                        new_entry.rhs    = 16'h0000;
                        new_entry.len    = 2'd1;
                        new_entry.cls    = class_of(in_byte);
                    end else begin
                        opc_d   = in_byte;
                        state_d = OPR;
                    end
                end
            end
            OPR: begin
                if (accept) begin
                    push             = 1'b1;
                    new_entry.opcode = opc_q;
                    new_entry.len    = 2'd2;
                    new_entry.cls    = opr_cls;
                    if (opr_cls == 4'd9 || opr_cls == 4'd10) begin
                        new_entry.rhs = {(SEXT_BRANCH ? {5{opc_q[2]}} : 5'b0),
                                         opc_q[2:0], in_byte};
                    end else begin
                        new_entry.rhs = {8'h00, in_byte};
                    end
                    state_d = OPC;
                end
            end
            default: state_d = OPC;
        endcase

        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        valid_d  = (count_d != '0);

        // New head: empty, the entry being pushed into an otherwise empty queue,
        // or an entry already resident in storage.
        if (count_d == '0) begin
            head_d = '0;
        end else if ((count_q - CW'(pop)) == '0) begin
            head_d = new_entry;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end

        if (flush) begin
            state_d  = OPC;
            opc_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
            head_d   = '0;
        end
    end

    // State, pointer, head and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OPC;
            opc_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            for (int unsigned i = 0; i < MEMD; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter QDEPTH, default 2; decoded-instruction queue depth; legal values 1, 2, 4 or 8.
REQ-002 SHALL have parameter SEXT_BRANCH, default 1; when 1, branch/call operands are sign-extended; when 0, they are zero-extended.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all queued and partial instructions.
REQ-006 SHALL have port in_valid, input, 1, byte-stream valid.
REQ-007 SHALL have port in_byte, input, 8, next instruction-stream byte.
REQ-008 SHALL have port in_ready, output, 1, byte accepted when in_valid && in_ready.
REQ-009 SHALL have port out_valid, output, 1, queue head holds a decoded instruction.
REQ-010 SHALL have port out_ready, input, 1, consumer pops the head when out_valid && out_ready.
REQ-011 SHALL have port out_opcode, output, 8, head opcode byte.
REQ-012 SHALL have port out_rhs, output, 16, head operand, extended per REQ-019.
REQ-013 SHALL have port out_len, output, 2, head byte length (1 or 2).
REQ-014 SHALL have port out_class, output, 4, head class code per REQ-018.
REQ-015 SHALL have port count, output, 4, number of queued entries (0..QDEPTH).

Function
REQ-016 Assembler FSM SHALL have two states, OPC and OPR; it resets to OPC.
REQ-017 In OPC, an accepted byte with bit7=0 SHALL enqueue a 1-byte entry (rhs=0, len=1) in the same edge; with bit7=1 it SHALL latch the opcode and go to OPR; in OPR, the accepted byte SHALL complete a 2-byte entry (len=2) and return to OPC.
REQ-018 out_class SHALL be: 0 NOP (0x00), 1 HALT (0x01), 2 STACK (0x03-0x06), 3 ALU1 (0x07), 4 OUT (0x08), 5 SETDP (0x0A), 6 LOAD (0x80-0x87), 7 STORE (0x90-0x97), 8 ALU2 (0x88-0x8F, 0x98-0xB7), 9 BRANCH (0xC0-0xC7), 10 CALL (0xD0-0xD7), 11 IF (0xF0-0xF7), 15 ILLEGAL (all other opcodes); ILLEGAL entries SHALL still be enqueued with their correct len.
REQ-019 rhs: BRANCH/CALL SHALL be {opcode[2:0],operand} as 11 bits extended per SEXT_BRANCH; all other 2-byte entries SHALL be {8'h00,operand}.
REQ-020 Queue SHALL be FIFO; outputs SHALL be registered from the head entry; when empty, out_opcode/out_rhs/out_len/out_class SHALL be 0.
REQ-021 in_ready SHALL be 1 in OPC when count<QDEPTH or a pop occurs this cycle; it SHALL be 1 in OPR when count<QDEPTH or a pop occurs this cycle.
REQ-022 Minimum latency: final byte accepted at edge N -> out_valid=1 after edge N; no combinational path from in_byte to out_*.
REQ-023 Simultaneous push and pop when full SHALL leave count unchanged and SHALL not lose or duplicate entries.
REQ-024 Read/write pointers SHALL wrap modulo QDEPTH.
REQ-025 flush SHALL have priority over push and pop: at the edge, count:=0, FSM:=OPC, latched opcode discarded, and the byte presented that cycle SHALL not be accepted (in_ready=0 while flush=1).
REQ-026 Pop with out_valid=0 SHALL be ignored.

Reset
REQ-027 While rst_n=0: FSM=OPC, count=0, pointers=0, out_valid=0, out_* =0, in_ready=0; in_ready SHALL rise in the first cycle after deassertion.
REQ-028 Reset asserted in OPR SHALL discard the partial instruction; the next accepted byte SHALL be treated as an opcode.

Verification
REQ-029 Bytes 0x01 -> one entry class=1, len=1, rhs=0x0000, out_valid next cycle.
REQ-030 Bytes 0xC7,0xFE with SEXT_BRANCH=1 -> class=9, len=2, rhs=0xFFFE; with SEXT_BRANCH=0 -> rhs=0x07FE.
REQ-031 QDEPTH=2, out_ready=0, bytes 0x00,0x88,0x05,0x07 -> count=2 after the 0x05 byte, in_ready=0, 0x07 stalled; out_ready=1 for one cycle -> 0x07 accepted that cycle, count stays 2.
REQ-032 Bytes 0x81 then flush=1 with in_valid=1, byte 0x22 -> 0x22 not accepted, count=0; next byte 0x00 -> class=0, len=1.
REQ-033 Byte 0x02 -> class=15, len=1; byte 0xE0, 0x11 -> class=15, len=2, rhs=0x0011.
REQ-034 Random byte stream with random out_ready vs. a reference model -> identical entry sequence, no overflow, count never exceeds QDEPTH.
